// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
//   Arbitrates the single register-file write port between the in-order
//   pipeline writeback (port A) and a long-latency unit such as mul/div or a
//   load miss (port B). It also keeps a pending scoreboard of destinations
//   owned by in-flight long-latency ops so that decode can stall on RAW
//   hazards.
//
//   Optional feature, selected by the macro RF_WB_STARVE_GUARD_EN:
//     defined   - B gets a wait counter. After STARVE_LIMIT consecutive
//                 refused cycles, B is granted one forced slot.
//     undefined - strict A priority. No counter and no forced state.
//
// Parameters
//   STARVE_LIMIT : consecutive refused cycles for B before a forced grant (1..15)
//   XLEN         : writeback data width
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   a_valid/a_ready/a_rd/a_data : pipeline writeback requester
//   b_valid/b_ready/b_rd/b_data : long-latency requester
//   issue_valid/issue_rd        : long-latency issue, marks issue_rd pending
//   rs1_reg/rs2_reg             : decode source registers to query
//   rs1_busy/rs2_busy           : combinational hazard flags for decode
//   rf_we/rf_rd/rf_wdata        : registered register-file write port
// ----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_reg,
    input  logic [4:0]      rs2_reg,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic xfer_a;
    logic xfer_b;

    // The ready rules never let A and B transfer in the same cycle.
    assign xfer_a = a_valid && a_ready;
    assign xfer_b = b_valid && b_ready;

`ifdef RF_WB_STARVE_GUARD_EN
    typedef enum logic {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } state_e;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        a_ready = (state_q == PRIO_A);
        b_ready = (state_q == FORCE_B) || !a_valid;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;
        if (!b_valid || xfer_b) begin
            wait_cnt_d = 4'd0;
        end else if (!b_ready) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        case (state_q)
            // Switch when the count reaches the limit. B then owns the
            // next cycle, so A wins exactly LIMIT cycles in a row.
            PRIO_A:  if (wait_cnt_d == LIMIT) state_d = FORCE_B;
            FORCE_B: if (xfer_b)              state_d = PRIO_A;
            default: state_d = PRIO_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PRIO_A;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign a_ready = 1'b1;
    assign b_ready = !a_valid;
`endif

    // ------------------------------------------------------------------
    // Pending scoreboard
    // ------------------------------------------------------------------
    logic [31:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (xfer_b) begin
            pending_d[b_rd] = 1'b0;
        end
        // The set is applied after the clear, so a new issue to the same rd
        // that B is retiring this cycle stays pending.
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    // Decode sees B's retiring rd as busy during the transfer cycle, because
    // the register file is only written on the following cycle.
    assign rs1_busy = (rs1_reg != 5'd0) &&
                      (pending_q[rs1_reg] || (xfer_b && (b_rd == rs1_reg)));
    assign rs2_busy = (rs2_reg != 5'd0) &&
                      (pending_q[rs2_reg] || (xfer_b && (b_rd == rs2_reg)));

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer_a) begin
            rf_we_d    = (a_rd != 5'd0);
            rf_rd_d    = a_rd;
            rf_wdata_d = a_data;
        end else if (xfer_b) begin
            rf_we_d    = (b_rd != 5'd0);
            rf_rd_d    = b_rd;
            rf_wdata_d = b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 32'd0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Randomized, self-checking bench for rf_wb_arbiter. A behavioural model
//   keeps the pending set, B's refused-cycle count and the expected write
//   port. The model is checked against the DUT on every falling edge.
//   Directed scenarios cover writeback, scoreboard, x0, set/clear collision,
//   starvation (guard build) and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_rf_wb_arbiter;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_valid, b_valid, issue_valid;
    logic            a_ready, b_ready, rs1_busy, rs2_busy, rf_we;
    logic [4:0]      a_rd, b_rd, issue_rd, rs1_reg, rs2_reg, rf_rd;
    logic [XLEN-1:0] a_data, b_data, rf_wdata;

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit              m_pend [32];
    int              m_wait;
    bit              m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wd;
    bit              m_xa, m_xb;

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wait = 0;
        m_we   = 1'b0;
        m_rd   = 5'd0;
        m_wd   = '0;
        m_xa   = 1'b0;
        m_xb   = 1'b0;
    endtask

    task automatic idle();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0;
        rs1_reg = 0; rs2_reg = 0;
    endtask

    // Called just after a rising edge with inputs already applied. Checks the
    // DUT at the falling edge, then advances the model over the next rising edge.
    task automatic cycle();
        bit ea, eb, xa, xb, e1, e2;
        @(negedge clk);
`ifdef RF_WB_STARVE_GUARD_EN
        ea = !(m_wait >= int'(LIMIT));
        eb = !ea || !a_valid;
`else
        ea = 1'b1;
        eb = !a_valid;
`endif
        xa = a_valid && ea;
        xb = b_valid && eb;
        e1 = (rs1_reg != 0) && (m_pend[rs1_reg] || (xb && b_rd == rs1_reg));
        e2 = (rs2_reg != 0) && (m_pend[rs2_reg] || (xb && b_rd == rs2_reg));
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("rs1_busy", rs1_busy, e1);
        chk("rs2_busy", rs2_busy, e2);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_wdata", rf_wdata, m_wd);
        end
        if (xa) begin
            m_we = (a_rd != 0); m_rd = a_rd; m_wd = a_data;
        end else if (xb) begin
            m_we = (b_rd != 0); m_rd = b_rd; m_wd = b_data;
        end else begin
            m_we = 1'b0;
        end
        if (xb) m_pend[b_rd] = 1'b0;
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        if (!b_valid || xb) m_wait = 0;
        else if (!eb) m_wait++;
        m_xa = xa;
        m_xb = xb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #3;
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_rd", rf_rd, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        chk("reset a_ready", a_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A writeback, rd=5
        a_valid = 1; a_rd = 5; a_data = 32'h11;
        cycle();
        idle();
        chk("wb rf_we", rf_we, 1);
        chk("wb rf_rd", rf_rd, 5);
        chk("wb rf_wdata", rf_wdata, 32'h11);
        cycle();
        chk("hold rf_we", rf_we, 0);
        chk("hold rf_rd", rf_rd, 5);
        chk("hold rf_wdata", rf_wdata, 32'h11);

        // Scoreboard: issue rd=7, then B retires it
        issue_valid = 1; issue_rd = 7;
        cycle();
        idle(); rs1_reg = 7;
        #1 chk("sb pending busy", rs1_busy, 1);
        b_valid = 1; b_rd = 7; b_data = 32'hABCD;
        #1 chk("sb retire-cycle busy", rs1_busy, 1);
        cycle();
        b_valid = 0;
        #1 chk("sb cleared busy", rs1_busy, 0);
        chk("sb rf_we", rf_we, 1);
        chk("sb rf_wdata", rf_wdata, 32'hABCD);
        cycle();

        // x0 handling
        idle(); a_valid = 1; a_rd = 0; a_data = 32'hFFFF;
        #1 chk("x0 a_ready", a_ready, 1);
        cycle();
        idle();
        chk("x0 rf_we", rf_we, 0);
        issue_valid = 1; issue_rd = 0;
        cycle();
        idle();
        #1 chk("x0 busy", rs1_busy, 0);
        cycle();

        // Same-cycle issue and B retire of rd=9: set wins
        issue_valid = 1; issue_rd = 9; b_valid = 1; b_rd = 9; b_data = 32'h99;
        cycle();
        idle(); rs2_reg = 9;
        #1 chk("collide rs2_busy", rs2_busy, 1);
        cycle();

`ifdef RF_WB_STARVE_GUARD_EN
        // Starvation guard: A wins LIMIT cycles, then B is forced
        idle(); a_valid = 1; a_rd = 1; a_data = 32'h1; b_valid = 1; b_rd = 2; b_data = 32'h2;
        for (int i = 0; i < int'(LIMIT); i++) begin
            #1 chk("starve a_ready", a_ready, 1);
            chk("starve b_ready", b_ready, 0);
            cycle();
        end
        chk("force a_ready", a_ready, 0);
        chk("force b_ready", b_ready, 1);
        cycle();
        b_valid = 0;
        #1 chk("resume a_ready", a_ready, 1);
        cycle();
        idle();
        cycle();
`endif

        // Reset mid-operation with pending bits 3 and 4 set and a write in flight
        idle(); issue_valid = 1; issue_rd = 3;
        cycle();
        issue_rd = 4;
        cycle();
        idle(); a_valid = 1; a_rd = 12; a_data = 32'h5A5A;
        cycle();
        idle(); rs1_reg = 3; rs2_reg = 4;
        #1 chk("pre-rst rs1_busy", rs1_busy, 1);
        chk("pre-rst rf_we", rf_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst rf_we", rf_we, 0);
        chk("rst rf_rd", rf_rd, 0);
        chk("rst rf_wdata", rf_wdata, 0);
        chk("rst rs1_busy", rs1_busy, 0);
        chk("rst rs2_busy", rs2_busy, 0);
        chk("rst a_ready", a_ready, 1);
        chk("rst b_ready", b_ready, 1);
        model_reset();
        a_valid = 1; a_rd = 13; a_data = 32'h77;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst rf_we", rf_we, 0);

        // Randomized traffic under the handshake protocol
        for (int n = 0; n < 600; n++) begin
            if (!(a_valid && !m_xa)) begin
                a_valid = ($urandom_range(0, 9) < 6);
                a_rd    = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!(b_valid && !m_xb)) begin
                b_valid = ($urandom_range(0, 9) < 5);
                b_rd    = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = ($urandom_range(0, 3) == 0) ? b_rd : 5'($urandom_range(0, 31));
            rs1_reg     = ($urandom_range(0, 1) == 0) ? b_rd : 5'($urandom_range(0, 31));
            rs2_reg     = ($urandom_range(0, 1) == 0) ? issue_rd : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles port B may wait before forced grant (range 1..15).
REQ-002 SHALL have parameter XLEN, default 32, meaning writeback data width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports a_valid in 1, a_ready out 1, a_rd in 5, a_data in XLEN: pipeline WB requester.
REQ-006 SHALL have ports b_valid in 1, b_ready out 1, b_rd in 5, b_data in XLEN: long-latency unit (mul/div, load miss) requester.
REQ-007 SHALL have ports issue_valid in 1, issue_rd in 5: long-latency op issued, destination marked pending.
REQ-008 SHALL have ports rs1_reg in 5, rs2_reg in 5, rs1_busy out 1, rs2_busy out 1: scoreboard query for decode stall.
REQ-009 SHALL have ports rf_we out 1, rf_rd out 5, rf_wdata out XLEN: drive the single register-file write port.

Function
REQ-010 SHALL transfer on a port when valid && ready in the same cycle; requester holds valid, rd, data stable until transfer.
REQ-011 SHALL use state machine {PRIO_A, FORCE_B}; PRIO_A: a_ready=1, b_ready=!a_valid; FORCE_B: b_ready=1, a_ready=0.
REQ-012 SHALL keep wait counter (4 bits): +1 each cycle b_valid && !b_ready, cleared on any B transfer or when b_valid=0.
REQ-013 SHALL transition PRIO_A->FORCE_B when counter reaches STARVE_LIMIT; FORCE_B->PRIO_A after the B transfer (one cycle).
REQ-014 SHALL register the winner: rf_we/rf_rd/rf_wdata valid one cycle after transfer, rf_we=1 only if transferred rd!=0.
REQ-015 SHALL drive rf_we=0 in cycles with no transfer; rf_rd/rf_wdata hold last value.
REQ-016 SHALL keep 32-bit pending vector: issue_valid sets bit issue_rd (ignored for rd=0); B transfer clears bit b_rd.
REQ-017 SHALL give set priority when issue and B clear hit the same rd in one cycle (bit ends 1).
REQ-018 SHALL compute rs1_busy/rs2_busy combinationally as pending[rsX_reg] OR (B transfer this cycle to rsX_reg, rsX_reg!=0); x0 never busy.
REQ-019 SHALL accept A transfers regardless of pending bits (no check); B transfer to non-pending rd still writes, vector unchanged.

Reset
REQ-020 SHALL on rst_n=0 asynchronously: state PRIO_A, counter 0, pending all 0, rf_we 0, rf_rd 0, rf_wdata 0.
REQ-021 SHALL drop any in-flight registered write on reset mid-operation (rf_we=0 first cycle after release).
REQ-022 SHALL drive a_ready=1, b_ready=1 combinationally during reset is NOT allowed: a_ready/b_ready follow REQ-011 from reset state, no transfer effect while rst_n=0.

Configuration
REQ-023 SHALL compile starvation guard only with macro RF_WB_STARVE_GUARD_EN defined: REQ-012/013 active.
REQ-024 SHALL without RF_WB_STARVE_GUARD_EN: no counter, no FORCE_B; strict A priority (a_ready=1, b_ready=!a_valid).

Verification
REQ-025 SHALL cover: a_valid=1 rd=5 data=0x11, b_valid=0 -> next cycle rf_we=1 rf_rd=5 rf_wdata=0x11.
REQ-026 SHALL cover: issue rd=7, then rs1_reg=7 -> rs1_busy=1; B writes rd=7 0xABCD -> rs1_busy=1 that cycle, 0 next; rf_wdata=0xABCD.
REQ-027 SHALL cover (guard on, STARVE_LIMIT=4): a_valid and b_valid held high -> A wins 4 cycles, 5th cycle a_ready=0 b_ready=1, then A resumes.
REQ-028 SHALL cover: a transfer rd=0 data=0xFFFF -> a_ready=1, rf_we stays 0; issue rd=0 -> rs1_busy for rs1_reg=0 stays 0.
REQ-029 SHALL cover: same cycle issue rd=9 and B transfer rd=9 -> pending[9]=1 afterward, rs2_busy(rs2_reg=9)=1.
REQ-030 SHALL cover: pending bits 3,4 set, rst_n pulsed low mid-cycle -> pending 0, rf_we 0, state PRIO_A immediately.
